// File: rtl/game_round_ctrl.sv
// game_round_ctrl -- round sequencer for a guess-the-number game.
//
// A game is ROUNDS rounds long. Each round asks the external generator for a
// new number (one-cycle gen_en), waits GEN_SETTLE cycles for its output to
// settle, captures it as target, then waits for the player to submit a guess.
// The submitted guess is then judged, and a one-cycle hit or miss pulse is
// produced.
//
// Optional feature: define ROUND_TIMEOUT_EN to make tick count time_left down
// and to end the round as a miss when the time runs out. Without it, tick is
// ignored and a round ends only on submit.
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   start         pulse; begins a game from IDLE or OVER
//   tick          timebase strobe (used only with ROUND_TIMEOUT_EN)
//   guess, submit player value and its commit pulse
//   gen_value     generator output, sampled GEN_SETTLE cycles after gen_en
//   gen_en        one-cycle generator request
//   target        number to match
//   score         hits this game (saturates at 15)
//   round_num     rounds completed this game
//   time_left     ticks remaining in the current round
//   hit, miss     one-cycle verdict pulses
//   busy          high while a game is in progress
//   game_over     high once all rounds are done
module game_round_ctrl #(
    parameter int ROUNDS     = 8,
    parameter int ROUND_TIME = 10,
    parameter int GEN_SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       tick,
    input  logic [3:0] guess,
    input  logic       submit,
    input  logic [3:0] gen_value,
    output logic       gen_en,
    output logic [3:0] target,
    output logic [3:0] score,
    output logic [3:0] round_num,
    output logic [3:0] time_left,
    output logic       hit,
    output logic       miss,
    output logic       busy,
    output logic       game_over
);

`ifdef ROUND_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [3:0] ROUNDS_L     = 4'(ROUNDS);
    localparam logic [3:0] ROUND_TIME_L = 4'(ROUND_TIME);
    localparam logic [2:0] SETTLE_L     = 3'(GEN_SETTLE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GEN,
        S_SETTLE,
        S_PLAY,
        S_JUDGE,
        S_OVER
    } state_t;

    state_t     state, state_nxt;
    logic [2:0] settle_cnt;
    logic [3:0] guess_q;
    logic       timed_out;
    logic       tick_en;
    logic       settle_done;
    logic       time_up;
    logic       match;
    logic       last_round;

    assign tick_en     = TIMEOUT_EN && tick;
    // The count is loaded with GEN_SETTLE (>= 1); leaving SETTLE on the cycle
    // it would reach zero gives exactly GEN_SETTLE cycles in SETTLE.
    assign settle_done = (settle_cnt <= 3'd1);
    // submit has priority over tick, so a timeout needs submit low.
    assign time_up     = !submit && tick_en && (time_left == 4'd1);
    // A timeout is always a miss, whatever guess_q still holds.
    assign match       = !timed_out && (guess_q == target);
    assign last_round  = ((round_num + 4'd1) == ROUNDS_L);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        gen_en    = 1'b0;
        hit       = 1'b0;
        miss      = 1'b0;
        busy      = 1'b1;
        game_over = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = S_GEN;
            end
            S_GEN: begin
                gen_en    = 1'b1;
                state_nxt = S_SETTLE;
            end
            S_SETTLE: if (settle_done) state_nxt = S_PLAY;
            S_PLAY:   if (submit || time_up) state_nxt = S_JUDGE;
            S_JUDGE: begin
                hit       = match;
                miss      = !match;
                state_nxt = last_round ? S_OVER : S_GEN;
            end
            S_OVER: begin
                busy      = 1'b0;
                game_over = 1'b1;
                if (start) state_nxt = S_GEN;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            target     <= '0;
            score      <= '0;
            round_num  <= '0;
            time_left  <= '0;
            settle_cnt <= '0;
            guess_q    <= '0;
            timed_out  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_OVER: begin
                    if (start) begin
                        score     <= '0;
                        round_num <= '0;
                    end
                end
                S_GEN: settle_cnt <= SETTLE_L;
                S_SETTLE: begin
                    settle_cnt <= settle_cnt - 3'd1;
                    if (settle_done) begin
                        target    <= gen_value;
                        time_left <= ROUND_TIME_L;
                        timed_out <= 1'b0;
                    end
                end
                S_PLAY: begin
                    if (submit) begin
                        guess_q <= guess;
                    end else if (tick_en) begin
                        time_left <= time_left - 4'd1;
                        if (time_left == 4'd1) timed_out <= 1'b1;
                    end
                end
                S_JUDGE: begin
                    if (match && score != 4'd15) score <= score + 4'd1;
                    round_num <= round_num + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_round_ctrl.sv
module tb_game_round_ctrl;

`ifdef ROUND_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    localparam int R  = 8;
    localparam int RT = 3;
    localparam int GS = 2;

    logic       clk = 1'b0;
    logic       rst, start, tick, submit;
    logic [3:0] guess, gen_value;
    logic       gen_en, hit, miss, busy, game_over;
    logic [3:0] target, score, round_num, time_left;

    game_round_ctrl #(.ROUNDS(R), .ROUND_TIME(RT), .GEN_SETTLE(GS)) dut (
        .clk(clk), .rst(rst), .start(start), .tick(tick), .guess(guess),
        .submit(submit), .gen_value(gen_value), .gen_en(gen_en),
        .target(target), .score(score), .round_num(round_num),
        .time_left(time_left), .hit(hit), .miss(miss), .busy(busy),
        .game_over(game_over)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // reference state of the game, kept at transaction level
    int score_m, rn_m, tgt_m, tl_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".target"},    target,    0);
        chk({tag, ".score"},     score,     0);
        chk({tag, ".round_num"}, round_num, 0);
        chk({tag, ".time_left"}, time_left, 0);
        chk({tag, ".gen_en"},    gen_en,    0);
        chk({tag, ".hit"},       hit,       0);
        chk({tag, ".miss"},      miss,      0);
        chk({tag, ".busy"},      busy,      0);
        chk({tag, ".game_over"}, game_over, 0);
    endtask

    task automatic start_game();
        start = 1'b1;
        cyc();
        start = 1'b0;
        score_m = 0;
        rn_m    = 0;
        chk("start.gen_en",    gen_en,    1);
        chk("start.score",     score,     0);
        chk("start.round_num", round_num, 0);
        chk("start.busy",      busy,      1);
        chk("start.game_over", game_over, 0);
    endtask

    // Called while the DUT sits in its gen_en cycle; runs the round through
    // the verdict and checks the bookkeeping afterwards.
    // mode 0: random, 1: tick down to the last tick then submit with it,
    // 2: immediate correct submit, 3: let the round time out.
    task automatic play_round(input int mode, input logic [3:0] gv);
        int         n;
        bit         done, exp_hit, do_sub, do_tick;
        logic [3:0] g;
        gen_value = gv;
        submit    = 1'b1;   // must be ignored outside PLAY
        start     = 1'b1;   // must be ignored while busy
        guess     = gv;
        cyc();
        chk("gen_en.width", gen_en, 0);
        chk("settle.busy",  busy,   1);
        cyc();
        submit = 1'b0;
        start  = 1'b0;
        chk("settle.round_num", round_num, rn_m);
        cyc();
        tgt_m = gv;
        tl_m  = RT;
        chk("play.target",    target,    tgt_m);
        chk("play.time_left", time_left, tl_m);
        chk("play.verdict",   {hit, miss}, 0);
        gen_value = 4'($urandom);
        n = 0;
        done = 0;
        exp_hit = 0;
        while (!done) begin
            case (mode)
                0: begin
                    do_sub  = ($urandom_range(0, 4) == 0) || (n >= 8);
                    do_tick = 1'($urandom_range(0, 1));
                    g       = ($urandom_range(0, 1) == 1) ? 4'(tgt_m) : 4'($urandom);
                end
                1: begin
                    do_tick = 1;
                    do_sub  = TO_EN ? (tl_m == 1) : (n >= 4);
                    g       = 4'(tgt_m);
                end
                2: begin
                    do_tick = 0;
                    do_sub  = 1;
                    g       = 4'(tgt_m);
                end
                default: begin
                    do_tick = 1;
                    do_sub  = !TO_EN && (n >= 4);
                    g       = 4'(tgt_m) ^ 4'h1;
                end
            endcase
            submit = do_sub;
            tick   = do_tick;
            guess  = g;
            cyc();
            submit = 1'b0;
            tick   = 1'b0;
            guess  = 4'($urandom);
            if (do_sub) begin
                exp_hit = (int'(g) == tgt_m);
                done = 1;
            end else if (TO_EN && do_tick) begin
                if (tl_m == 1) begin
                    tl_m = 0;
                    exp_hit = 0;
                    done = 1;
                end else begin
                    tl_m--;
                end
            end
            n++;
            if (!done) begin
                chk("play.no_verdict", {hit, miss}, 0);
                chk("play.time_left",  time_left,  tl_m);
            end
        end
        chk("judge.hit",       hit,       exp_hit);
        chk("judge.miss",      miss,      !exp_hit);
        chk("judge.time_left", time_left, tl_m);
        if (exp_hit && score_m < 15) score_m++;
        rn_m++;
        cyc();
        chk("post.pulse",     {hit, miss}, 0);
        chk("post.score",     score,      score_m);
        chk("post.round_num", round_num,  rn_m);
        chk("post.target",    target,     tgt_m);
        chk("post.game_over", game_over,  rn_m == R);
        chk("post.gen_en",    gen_en,     rn_m != R);
        chk("post.busy",      busy,       rn_m != R);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; tick = 1'b0; submit = 1'b0;
        guess = '0; gen_value = '0;
        cyc();
        cyc();
        check_reset_vals("reset");
        rst = 1'b0;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("idle.gen_en", gen_en, 0);
        chk("idle.busy",   busy,   0);

        // game A: directed opening rounds, then random
        start_game();
        play_round(2, 4'd5);
        play_round(1, 4'($urandom));
        play_round(3, 4'($urandom));
        for (int i = 3; i < R; i++) play_round(0, 4'($urandom));
        // OVER holds its results; submit/tick are ignored there
        for (int i = 0; i < 3; i++) begin
            submit = 1'b1;
            tick   = 1'b1;
            guess  = 4'(tgt_m);
            cyc();
            chk("over.score",     score,     score_m);
            chk("over.round_num", round_num, R);
            chk("over.target",    target,    tgt_m);
            chk("over.game_over", game_over, 1);
            chk("over.verdict",   {hit, miss}, 0);
        end
        submit = 1'b0;
        tick   = 1'b0;

        // game B: all hits
        start_game();
        for (int i = 0; i < R; i++) play_round(2, 4'($urandom));
        chk("allhit.score", score, R);

        // game C: restart from OVER, reset during PLAY of round 3
        start_game();
        for (int i = 0; i < 3; i++) play_round(0, 4'($urandom));
        chk("midrst.round_num", round_num, 3);
        gen_value = 4'd9;
        cyc();
        cyc();
        cyc();
        chk("midrst.in_play", target, 9);
        rst    = 1'b1;
        submit = 1'b1;
        guess  = 4'd9;
        cyc();
        rst    = 1'b0;
        submit = 1'b0;
        check_reset_vals("rst_play");

        // game D: reset during the gen_en cycle, then a random game
        start_game();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_reset_vals("rst_gen");
        start_game();
        for (int i = 0; i < R; i++) play_round(int'($urandom_range(0, 3)), 4'($urandom));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 Parameter ROUNDS, default 8, rounds per game; legal range 1..15.
REQ-002 Parameter ROUND_TIME, default 10, tick strobes allowed per round; legal range 1..15.
REQ-003 Parameter GEN_SETTLE, default 2, clk cycles waited after gen_en before sampling gen_value; legal range 1..7.
REQ-004 clk  in  1  system clock; all state changes on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse that begins a game.
REQ-007 tick  in  1  one-cycle timebase strobe, e.g. 1 Hz.
REQ-008 guess  in  4  player switch value.
REQ-009 submit  in  1  one-cycle pulse that commits guess.
REQ-010 gen_value  in  4  random number from the generator.
REQ-011 gen_en  out  1  one-cycle request that drives the generator's enable input.
REQ-012 target  out  4  number the player must match.
REQ-013 score  out  4  hits this game.
REQ-014 round_num  out  4  rounds completed this game.
REQ-015 time_left  out  4  ticks remaining in the current round.
REQ-016 hit, miss  out  1 each  one-cycle verdict pulses.
REQ-017 busy  out  1  high in every state except IDLE and OVER.
REQ-018 game_over  out  1  high only in OVER.

Function
REQ-019 The FSM SHALL have the states IDLE, GEN, SETTLE, PLAY, JUDGE and OVER, all registered.
REQ-020 IDLE/OVER: start SHALL clear score and round_num and move to GEN on the next edge.
REQ-021 GEN: gen_en SHALL be high for exactly this one cycle, then the FSM SHALL move to SETTLE with settle count = GEN_SETTLE.
REQ-022 SETTLE: the count SHALL decrement each cycle; at zero, target <= gen_value, time_left <= ROUND_TIME, then move to PLAY.
REQ-023 PLAY: submit SHALL latch guess and move to JUDGE; tick SHALL decrement time_left.
REQ-024 PLAY: tick with time_left==1 and no submit SHALL set time_left to 0 and move to JUDGE as a timeout miss.
REQ-025 If submit and tick occur in the same cycle, submit SHALL win and time_left SHALL NOT decrement.
REQ-026 JUDGE: latched guess==target SHALL pulse hit and increment score, saturating at 15; otherwise it SHALL pulse miss.
REQ-027 JUDGE: round_num SHALL increment; the FSM SHALL move to OVER if the new value equals ROUNDS, else to GEN.
REQ-028 start outside IDLE/OVER, and submit outside PLAY, SHALL be ignored.
REQ-029 Latency from start to the gen_en pulse SHALL be 1 cycle; gen_en to PLAY entry SHALL be GEN_SETTLE+1 cycles.
REQ-030 target, score and round_num SHALL hold their values in OVER until the next start.

Reset
REQ-031 rst SHALL take priority over all inputs, and the block SHALL enter IDLE on the next edge.
REQ-032 Reset values SHALL be: target=0, score=0, round_num=0, time_left=0, gen_en=0, hit=0, miss=0, busy=0, game_over=0, settle count=0.
REQ-033 Reset asserted mid-round, including in the GEN cycle, SHALL drive gen_en low on the next edge and SHALL NOT produce a hit or miss pulse.

Configuration
REQ-034 Macro ROUND_TIMEOUT_EN, when defined, SHALL enable the tick-driven countdown and timeout (REQ-023 tick part, REQ-024, REQ-025).
REQ-035 When ROUND_TIMEOUT_EN is undefined, tick SHALL be ignored, time_left SHALL hold ROUND_TIME during PLAY, and PLAY SHALL exit only on submit.

Verification
REQ-036 rst, then start; gen_value=5 -> gen_en one cycle, target=5 after 3 cycles (GEN_SETTLE=2), busy=1.
REQ-037 target=5, submit with guess=5 -> hit one cycle, score=1, round_num=1, next gen_en follows.
REQ-038 ROUND_TIMEOUT_EN, ROUND_TIME=3, 3 ticks with no submit -> time_left 3,2,1,0, then miss, score unchanged.
REQ-039 time_left=1, tick and submit same cycle with a correct guess -> hit, time_left stays 1.
REQ-040 ROUNDS=8, all hits -> game_over=1 after 8th verdict, score=8; start -> score=0, round_num=0, gen_en.
REQ-041 rst asserted in PLAY with round_num=3 -> IDLE next edge, all outputs at reset values, no verdict pulse.
